// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin over WIDTH bits, DIGIT bits per clock,
// with a registered borrow between digits and a start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_SIGNED_EN (signed overflow flag on ovf_o;
// when undefined ovf_o is tied low and no sign-bit capture exists).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [DIGIT:0]   t;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             ovf_q, ovf_d;
`endif

    // Next-state: operand capture, one digit per RUN cycle, publish on the last digit.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_SIGNED_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ovf_d    = ovf_q;
`endif
        // Operands shift right, so the current digit always sits in the low bits.
        t = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = bin_i;
                    cnt_d    = '0;
                    state_d  = StRun;
`ifdef SERIAL_SUB_SIGNED_EN
                    a_sign_d = a_i[WIDTH-1];
                    b_sign_d = b_i[WIDTH-1];
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                // Result digits enter at the top so digit 0 ends at the bottom after N shifts.
                res_d    = (res_q >> DIGIT) | (WIDTH'(t[DIGIT-1:0]) << (WIDTH - DIGIT));
                borrow_d = t[DIGIT];
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d  = res_d;
                    bout_d  = t[DIGIT];
                    state_d = StDone;
`ifdef SERIAL_SUB_SIGNED_EN
                    ovf_d   = (a_sign_q != b_sign_q) && (res_d[WIDTH-1] != a_sign_q);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_SIGNED_EN
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign diff_o = diff_q;
    assign bout_o = bout_q;
`ifdef SERIAL_SUB_SIGNED_EN
    assign ovf_o  = ovf_q;
`else
    assign ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit
// instance, checked every cycle against a transaction-level model, plus literal vectors.
module tb_serial_subtractor;

    localparam int W0 = 8;
    localparam int N0 = 8;
    localparam int W1 = 16;
    localparam int N1 = 4;
`ifdef SERIAL_SUB_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic        clk, rst;
    logic        start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bout16, ovf16;
    logic [15:0] a16, b16, diff16;

    int n_chk  = 0;
    int n_pass = 0;

    serial_subtractor #(.WIDTH(W0), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
        .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8), .ovf_o(ovf8)
    );

    serial_subtractor #(.WIDTH(W1), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .start_i(start16), .a_i(a16), .b_i(b16), .bin_i(bin16),
        .busy_o(busy16), .done_o(done16), .diff_o(diff16), .bout_o(bout16), .ovf_o(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Transaction model: an accepted start at edge E0 finishes at edge E0+N.
    longint     cyc = 0;
    bit         m_act[2];
    longint     m_acc[2];
    logic [63:0] m_diff[2], p_diff[2];
    bit         m_bout[2], m_ovf[2], p_bout[2], p_ovf[2];

    task automatic model_step(input int d, input bit s, input logic [63:0] a,
                              input logic [63:0] b, input bit bin, input int n, input int w);
        logic [63:0] r, mask;
        bit running;
        if (rst) begin
            m_act[d] = 1'b0; m_diff[d] = '0; m_bout[d] = 1'b0; m_ovf[d] = 1'b0;
            return;
        end
        running = m_act[d] && (cyc - m_acc[d] <= longint'(n));
        if (running && (cyc - m_acc[d] == longint'(n))) begin
            m_diff[d] = p_diff[d]; m_bout[d] = p_bout[d]; m_ovf[d] = p_ovf[d];
        end
        if (!running && s) begin
            mask     = (64'd1 << w) - 64'd1;
            r        = a - b - 64'(bin);
            m_acc[d] = cyc;
            m_act[d] = 1'b1;
            p_diff[d] = r & mask;
            p_bout[d] = r[w];
            p_ovf[d]  = SignedEn && (a[w-1] != b[w-1]) && (p_diff[d][w-1] != a[w-1]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, start8, 64'(a8), 64'(b8), bin8, N0, W0);
            model_step(1, start16, 64'(a16), 64'(b16), bin16, N1, W1);
        end
    end

    task automatic check_dut(input int d, input int n, input logic busy, input logic done,
                             input logic [63:0] diff, input logic bout, input logic ovf);
        bit eb, ed;
        logic [63:0] ediff;
        bit ebo, eov;
        if (rst) begin
            eb = 0; ed = 0; ediff = '0; ebo = 0; eov = 0;
        end else begin
            eb = m_act[d] && (cyc - m_acc[d] < longint'(n));
            ed = m_act[d] && (cyc - m_acc[d] == longint'(n));
            ediff = m_diff[d]; ebo = m_bout[d]; eov = m_ovf[d];
        end
        chk($sformatf("dut%0d busy @%0d", d, cyc), 64'(busy), 64'(eb));
        chk($sformatf("dut%0d done @%0d", d, cyc), 64'(done), 64'(ed));
        chk($sformatf("dut%0d diff @%0d", d, cyc), diff, ediff);
        chk($sformatf("dut%0d bout @%0d", d, cyc), 64'(bout), 64'(ebo));
        chk($sformatf("dut%0d ovf @%0d", d, cyc), 64'(ovf), 64'(eov));
        chk($sformatf("dut%0d busy&done @%0d", d, cyc), 64'(busy & done), 64'd0);
    endtask

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, N0, busy8, done8, 64'(diff8), bout8, ovf8);
            check_dut(1, N1, busy16, done16, 64'(diff16), bout16, ovf16);
        end
    end

    // Waits (bounded) for done8; entered just after an edge, leaves at posedge+1.
    task automatic wait_done8(output logic [7:0] d, output logic bo, output logic ov,
                              output int busy_cyc, output int dones);
        bit seen = 0;
        d = '0; bo = 1'b0; ov = 1'b0; busy_cyc = 0; dones = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy8) busy_cyc++;
            if (done8) begin
                dones++; seen = 1; d = diff8; bo = bout8; ov = ovf8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic ebo, input logic eov, input string nm);
        logic [7:0] d;
        logic bo, ov;
        int bc, dn;
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait_done8(d, bo, ov, bc, dn);
        chk({nm, " diff"}, 64'(d), 64'(ed));
        chk({nm, " bout"}, 64'(bo), 64'(ebo));
        chk({nm, " ovf"}, 64'(ov), 64'(eov));
        chk({nm, " done pulses"}, 64'(dn), 64'd1);
        chk({nm, " busy cycles"}, 64'(bc), 64'd8);
    endtask

    initial begin
        logic [7:0] d;
        logic bo, ov;
        int bc, dn, last, dones, seen_done;

        rst = 1'b1;
        start8 = 0; a8 = '0; b8 = '0; bin8 = 0;
        start16 = 0; a16 = '0; b16 = '0; bin16 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset diff", 64'(diff8), 64'd0);
        chk("reset bout", 64'(bout8), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "5-3");
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "0-1");
        op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "10-F-1");
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, SignedEn, "80-1");
        op8(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, "7F-1");

        // Starts during RUN must not re-capture operands.
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1;
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        wait_done8(d, bo, ov, bc, dn);
        chk("start-in-run diff", 64'(d), 64'h02);
        chk("start-in-run done", 64'(dn), 64'd1);

        // Asynchronous reset in the middle of RUN.
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("busy before rst", 64'(busy8), 64'd1);
        chk("diff before rst", 64'(diff8), 64'h02);
        rst = 1'b1;
        #1;
        chk("async rst busy", 64'(busy8), 64'd0);
        chk("async rst done", 64'(done8), 64'd0);
        chk("async rst diff", 64'(diff8), 64'd0);
        chk("async rst bout", 64'(bout8), 64'd0);
        chk("async rst ovf", 64'(ovf8), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) seen_done++;
        end
        chk("no done after abort", 64'(seen_done), 64'd0);
        @(posedge clk);
        #1;
        op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, "post-rst 33-11");

        // Random back-to-back traffic on both instances; start held high.
        start8 = 1'b1; start16 = 1'b1;
        last = -1; dones = 0;
        for (int c = 0; c < 8000 && dones < 1000; c++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            @(negedge clk);
            if (done16) begin
                if (last >= 0) chk("done16 period", 64'(c - last), 64'd5);
                last = c;
                dones++;
            end
            @(posedge clk);
            #1;
        end
        chk("random ops completed", 64'(dones), 64'd1000);
        start8 = 1'b0; start16 = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing diff = a − b − bin over WIDTH-bit operands, DIGIT bits per clock, with a registered borrow chain between digits. It is the sequential successor to the single-bit gate-level full subtractor. It replaces wide combinational borrow ripples in area-constrained datapaths with a start/done handshake. Throughput trades against area via DIGIT.

## Interface
- WIDTH, 8: operand/result width in bits; ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT.
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  registered result; holds until next completion.
- bout  output  1  final borrow-out (unsigned a < b + bin).
- ovf  output  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE, RUN, DONE. Digit counter is ceil(log2(N+1)) bits. Internal state also includes operand shift registers and a borrow register.
- IDLE/DONE with start=1: load a, b, and the borrow register ← bin; counter ← 0; go to RUN.
- IDLE/DONE with start=0: DONE → IDLE; IDLE stays.
- Each RUN edge processes digit k = counter, i.e. bits [k·DIGIT +: DIGIT].
  - t = a_k − b_k − borrow, computed DIGIT+1 bits wide.
  - The low DIGIT bits of t go to the partial result.
  - borrow ← t[DIGIT], the sign of t.
  - counter increments.
  - Digits are processed LSB first.
- On the RUN edge processing digit N−1:
  - diff ← full partial result.
  - bout ← final borrow.
  - ovf updated.
  - done ← 1; state → DONE.
- diff, bout, and ovf change only on that edge. They are stable during RUN and show the previous result.
- start while in RUN is ignored; operands are not re-captured.
- Arithmetic is modulo 2^WIDTH. Invariant: {bout, diff} = a − b − bin as (WIDTH+1)-bit two's complement.

## Timing
- Reset (async assert, any state) sets: state IDLE, busy 0, done 0, diff 0, bout 0, ovf 0, counter 0, borrow 0.
- Reset mid-RUN aborts the operation: no done pulse, outputs cleared.
- Reset deassertion is assumed synchronous to clk from the upstream reset synchroniser.
- Latency: start sampled at edge E0; done is high in the cycle after edge E_N; result is visible from the same edge.
- busy is high from E0 through E_N; done falls at E_{N+1}.
- Back-to-back: start=1 while done=1 is accepted at E_{N+1}. Sustained throughput is one result per N+1 cycles.
- done and busy are never high simultaneously.

## Configuration
- SERIAL_SUB_SIGNED_EN defined:
  - ovf = (a[WIDTH−1] ≠ b[WIDTH−1]) & (diff[WIDTH−1] ≠ a[WIDTH−1]), evaluated on the completion edge from the captured operand sign bits.
  - bin participates in the result only; it is not a separate overflow term.
- SERIAL_SUB_SIGNED_EN undefined:
  - ovf is tied to 0.
  - No sign-bit capture logic is synthesised.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 → after 9 edges diff=0x02, bout=0, done pulses once, busy high for exactly 8 cycles.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- With SERIAL_SUB_SIGNED_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1; a=0x7F, b=0x01 → diff=0x7E, ovf=0. Without the macro, ovf=0 for both cases.
- start pulses during RUN with different a/b → ignored; the result matches the originally captured operands.
- rst asserted at RUN cycle 4 → all outputs 0 immediately with no clock edge, no done pulse, state IDLE. A subsequent start computes correctly.
- WIDTH=16, DIGIT=4: random 1000 operand sets, back-to-back starts on done. Each result is checked against a − b − bin with a golden model; done period is 5 cycles.
